// File: rtl/usart_rx_pkg.sv
// Shared constants and state encoding for the RS232 receive path.
// Optional even-parity support is enabled with the USART_RX_PARITY_EN macro.
package usart_rx_pkg;

    // Baud counter width and default timing for 115200 baud from 50 MHz
    localparam int unsigned CNT_W          = 13;
    localparam int unsigned BPS_PARA_DEF   = 433;
    localparam int unsigned BPS_PARA_2_DEF = 216;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StStart = 3'd1,
        StData  = 3'd2,
        StStop  = 3'd3,
        StBreak = 3'd4
`ifdef USART_RX_PARITY_EN
        ,
        StParity = 3'd5
`endif
    } rx_state_t;

    // True when data plus parity bit hold an even number of ones
    function automatic logic even_parity_ok(input logic [7:0] data, input logic par);
        return ~(^{data, par});
    endfunction

endpackage

// File: rtl/usart_rx_sync.sv
// Brings the asynchronous serial line into the clk domain and flags the
// falling edge that marks a potential start bit.
module usart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic rs232_rx,
    output logic line,
    output logic start_edge
);

    logic sync1;
    logic sync2;
    logic prev;

    // Two synchroniser flops plus one delay flop; reset low so a line that is
    // already low out of reset cannot produce an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= rs232_rx;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign line       = sync2;
    assign start_edge = prev & ~sync2;

endmodule

// File: rtl/usart_rx.sv
// RS232 receiver, 8N1 by default, LSB first, mid-bit sampling.
// Define USART_RX_PARITY_EN for 8E1 framing with parity checking.
module usart_rx
    import usart_rx_pkg::*;
#(
    parameter int unsigned BPS_PARA   = BPS_PARA_DEF,
    parameter int unsigned BPS_PARA_2 = BPS_PARA_2_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rs232_rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_busy,
    output logic       frame_err,
    output logic       parity_err
);

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(BPS_PARA);
    localparam logic [CNT_W-1:0] CntMid = CNT_W'(BPS_PARA_2);

    logic             line;
    logic             start_edge;
    logic             sample;
    rx_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;

    usart_rx_sync u_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .rs232_rx   (rs232_rx),
        .line       (line),
        .start_edge (start_edge)
    );

    assign sample = (cnt == CntMid);

`ifdef USART_RX_PARITY_EN
    logic par_bit;
    logic par_err_q;
    assign parity_err = par_err_q;
`else
    assign parity_err = 1'b0;
`endif

    // Frame FSM with baud counter, shift register and registered pulse outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= StIdle;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            rx_busy   <= 1'b0;
            frame_err <= 1'b0;
`ifdef USART_RX_PARITY_EN
            par_bit   <= 1'b0;
            par_err_q <= 1'b0;
`endif
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
`ifdef USART_RX_PARITY_EN
            par_err_q <= 1'b0;
`endif
            cnt <= (cnt == CntMax) ? '0 : cnt + CNT_W'(1);

            unique case (state)
                StIdle: begin
                    cnt <= '0;
                    if (start_edge) begin
                        state   <= StStart;
                        rx_busy <= 1'b1;
                    end
                end
                StStart: begin
                    if (sample) begin
                        if (line) begin
                            // Line back high mid start bit: glitch, drop silently
                            state   <= StIdle;
                            rx_busy <= 1'b0;
                            cnt     <= '0;
                        end else begin
                            state   <= StData;
                            bit_idx <= '0;
                        end
                    end
                end
                StData: begin
                    if (sample) begin
                        shreg   <= {line, shreg[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
`ifdef USART_RX_PARITY_EN
                            state <= StParity;
`else
                            state <= StStop;
`endif
                        end
                    end
                end
`ifdef USART_RX_PARITY_EN
                StParity: begin
                    if (sample) begin
                        par_bit <= line;
                        state   <= StStop;
                    end
                end
`endif
                StStop: begin
                    if (sample) begin
                        cnt <= '0;
                        if (!line) begin
                            // Framing error wins over parity; wait out the break
                            frame_err <= 1'b1;
                            state     <= StBreak;
                        end else begin
`ifdef USART_RX_PARITY_EN
                            if (even_parity_ok(shreg, par_bit)) begin
                                rx_data  <= shreg;
                                rx_valid <= 1'b1;
                            end else begin
                                par_err_q <= 1'b1;
                            end
`else
                            rx_data  <= shreg;
                            rx_valid <= 1'b1;
`endif
                            state   <= StIdle;
                            rx_busy <= 1'b0;
                        end
                    end
                end
                StBreak: begin
                    cnt <= '0;
                    if (line) begin
                        state   <= StIdle;
                        rx_busy <= 1'b0;
                    end
                end
                default: begin
                    state   <= StIdle;
                    rx_busy <= 1'b0;
                    cnt     <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_usart_rx.sv
// Self-checking bench for usart_rx: vector table, directed corner sequences
// and randomized frames checked against a frame-level reference model.
module tb_usart_rx;

    localparam int BIT  = 250;             // clk cycles per bit in this bench
    localparam int FAST = 245;             // sender +2% baud
    localparam int SLOW = 255;             // sender -2% baud
`ifdef USART_RX_PARITY_EN
    localparam bit HAS_PAR = 1'b1;
`else
    localparam bit HAS_PAR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rs232_rx = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_busy;
    logic       frame_err;
    logic       parity_err;

    usart_rx #(
        .BPS_PARA   (BIT - 1),
        .BPS_PARA_2 ((BIT - 1) / 2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rs232_rx   (rs232_rx),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_busy    (rx_busy),
        .frame_err  (frame_err),
        .parity_err (parity_err)
    );

    always #10 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       pflip;
        int         bit_cyc;
        int         exp_valid;
        int         exp_ferr;
        int         exp_perr;
        logic [7:0] exp_data;
    } vec_t;

    vec_t       vecs[$];
    int         checks = 0;
    int         errors = 0;
    int         n_valid = 0;
    int         n_ferr = 0;
    int         n_perr = 0;
    int         cyc = 0;
    int         valid_cyc = 0;
    logic [7:0] got_q[$];

    // Pulse monitor: counts strobes and checks they never coincide
    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            if (rx_valid) begin
                n_valid++;
                valid_cyc = cyc;
                got_q.push_back(rx_data);
            end
            if (frame_err) n_ferr++;
            if (parity_err) n_perr++;
            if (rx_valid || frame_err || parity_err) begin
                checks++;
                if (int'(rx_valid) + int'(frame_err) + int'(parity_err) > 1) begin
                    errors++;
                    $display("FAIL exclusive pulses: valid=%0b ferr=%0b perr=%0b required at most one",
                             rx_valid, frame_err, parity_err);
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic drive_bit(input logic v, input int n);
        rs232_rx = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic idle(input int n);
        rs232_rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Serialises one frame: start, 8 data LSB first, optional parity, stop
    task automatic send_frame(input logic [7:0] d, input int bc, input logic stop,
                              input logic par, input bit use_par, input int hold_low);
        drive_bit(1'b0, bc);
        for (int i = 0; i < 8; i++) drive_bit(d[i], bc);
        if (use_par) drive_bit(par, bc);
        drive_bit(stop, bc);
        if (hold_low > 0) drive_bit(1'b0, hold_low);
        rs232_rx = 1'b1;
    endtask

    function automatic logic even_bit(input logic [7:0] d, input logic flip);
        return logic'($countones(d) % 2) ^ flip;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, " rx_data"}, int'(rx_data), 0);
        check({tag, " rx_valid"}, int'(rx_valid), 0);
        check({tag, " rx_busy"}, int'(rx_busy), 0);
        check({tag, " frame_err"}, int'(frame_err), 0);
        check({tag, " parity_err"}, int'(parity_err), 0);
    endtask

    // Watchdog so the run always ends
    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int         v0, f0, p0, s0, fell;
        bit         saw_busy;
        logic [7:0] model_data;
        logic [7:0] d;
        logic       stop, par, bad_par;
        int         bc, gap, hold, ev, ef, ep, lat_exp;
        bit         last_bad_stop;

        vecs.push_back('{8'h55, 1'b1, 1'b0, BIT,  1, 0, 0, 8'h55});
        vecs.push_back('{8'h3C, 1'b1, 1'b0, FAST, 1, 0, 0, 8'h3C});
        vecs.push_back('{8'hC3, 1'b1, 1'b0, SLOW, 1, 0, 0, 8'hC3});
        vecs.push_back('{8'h3C, 1'b1, 1'b0, SLOW, 1, 0, 0, 8'h3C});
        vecs.push_back('{8'hFF, 1'b0, 1'b0, BIT,  0, 1, 0, 8'h3C});
        vecs.push_back('{8'h12, 1'b1, 1'b0, BIT,  1, 0, 0, 8'h12});
        vecs.push_back('{8'h00, 1'b1, 1'b0, BIT,  1, 0, 0, 8'h00});
        vecs.push_back('{8'h80, 1'b1, 1'b0, BIT,  1, 0, 0, 8'h80});
        if (HAS_PAR) begin
            vecs.push_back('{8'h07, 1'b1, 1'b1, BIT, 0, 0, 1, 8'h80});
            vecs.push_back('{8'h07, 1'b1, 1'b0, BIT, 1, 0, 0, 8'h07});
            vecs.push_back('{8'h07, 1'b0, 1'b1, BIT, 0, 1, 0, 8'h07});
            vecs.push_back('{8'hA5, 1'b1, 1'b0, BIT, 1, 0, 0, 8'hA5});
        end

        // Reset state
        repeat (5) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        idle(20);

        // Vector table
        for (int i = 0; i < vecs.size(); i++) begin
            idle(20);
            v0 = n_valid; f0 = n_ferr; p0 = n_perr; s0 = cyc;
            send_frame(vecs[i].data, vecs[i].bit_cyc, vecs[i].stop,
                       even_bit(vecs[i].data, vecs[i].pflip), HAS_PAR,
                       vecs[i].stop ? 0 : 2 * BIT);
            check($sformatf("vec%0d valid count", i), n_valid - v0, vecs[i].exp_valid);
            check($sformatf("vec%0d frame_err count", i), n_ferr - f0, vecs[i].exp_ferr);
            check($sformatf("vec%0d parity_err count", i), n_perr - p0, vecs[i].exp_perr);
            check($sformatf("vec%0d rx_data", i), int'(rx_data), int'(vecs[i].exp_data));
            if (i == 0) begin
                // About 9.5 (10.5 with parity) bit times plus sync delay after start edge
                lat_exp = (HAS_PAR ? 21 : 19) * BIT / 2 + 3;
                checks++;
                if ((valid_cyc - s0) < lat_exp - 4 || (valid_cyc - s0) > lat_exp + 4) begin
                    errors++;
                    $display("FAIL latency: got %0d cycles required %0d +/-4",
                             valid_cyc - s0, lat_exp);
                end
            end
        end

        // Back-to-back frames, no idle between them
        idle(20);
        got_q.delete();
        v0 = n_valid;
        send_frame(8'hA5, BIT, 1'b1, even_bit(8'hA5, 1'b0), HAS_PAR, 0);
        send_frame(8'h3C, BIT, 1'b1, even_bit(8'h3C, 1'b0), HAS_PAR, 0);
        check("b2b valid count", n_valid - v0, 2);
        check("b2b queue size", got_q.size(), 2);
        if (got_q.size() == 2) begin
            check("b2b first byte", int'(got_q[0]), 'hA5);
            check("b2b second byte", int'(got_q[1]), 'h3C);
        end

        // 100-cycle low glitch on an idle line
        idle(20);
        v0 = n_valid; f0 = n_ferr;
        saw_busy = 1'b0;
        fell = -1;
        rs232_rx = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (rx_busy) saw_busy = 1'b1;
        end
        rs232_rx = 1'b1;
        for (int k = 100; k < 500 && fell < 0; k++) begin
            @(negedge clk);
            if (rx_busy) saw_busy = 1'b1;
            else if (saw_busy) fell = k + 1;
        end
        check("glitch busy seen", int'(saw_busy), 1);
        checks++;
        if (fell < BIT / 2 - 4 || fell > BIT / 2 + 8) begin
            errors++;
            $display("FAIL glitch busy fall: got cycle %0d required near %0d", fell, BIT / 2 + 3);
        end
        idle(BIT);
        check("glitch valid count", n_valid - v0, 0);
        check("glitch frame_err count", n_ferr - f0, 0);

        // Reset in the middle of data bit 4 of 0x81
        idle(20);
        v0 = n_valid; f0 = n_ferr;
        fork
            send_frame(8'h81, BIT, 1'b1, even_bit(8'h81, 1'b0), HAS_PAR, 0);
            begin
                repeat (5 * BIT + BIT / 2) @(negedge clk);
                rst_n = 1'b0;
                repeat (2) @(negedge clk);
                check_reset_outputs("midframe reset");
                rst_n = 1'b1;
            end
        join
        check("midframe valid count", n_valid - v0, 0);
        check("midframe frame_err count", n_ferr - f0, 0);
        idle(20);
        v0 = n_valid;
        send_frame(8'h42, BIT, 1'b1, even_bit(8'h42, 1'b0), HAS_PAR, 0);
        check("post-reset valid count", n_valid - v0, 1);
        check("post-reset rx_data", int'(rx_data), 'h42);

        // Randomized frames against the frame-level model
        model_data = 8'h42;
        last_bad_stop = 1'b0;
        for (int r = 0; r < 8; r++) begin
            d = 8'($urandom);
            case ($urandom_range(0, 2))
                0: bc = FAST;
                1: bc = SLOW;
                default: bc = BIT;
            endcase
            stop = ($urandom_range(0, 3) != 0);
            bad_par = HAS_PAR && ($urandom_range(0, 3) == 0);
            par = even_bit(d, bad_par);
            hold = stop ? 0 : $urandom_range(0, 2 * BIT);
            gap = last_bad_stop ? 20 : (($urandom_range(0, 1) == 0) ? 0 : $urandom_range(3, 200));
            idle(gap);
            // Expected outcome straight from the framing rules
            ev = 0; ef = 0; ep = 0;
            if (!stop) ef = 1;
            else if (HAS_PAR && (($countones(d) + int'(par)) % 2 != 0)) ep = 1;
            else begin
                ev = 1;
                model_data = d;
            end
            v0 = n_valid; f0 = n_ferr; p0 = n_perr;
            send_frame(d, bc, stop, par, HAS_PAR, hold);
            check($sformatf("rand%0d valid count", r), n_valid - v0, ev);
            check($sformatf("rand%0d frame_err count", r), n_ferr - f0, ef);
            check($sformatf("rand%0d parity_err count", r), n_perr - p0, ep);
            check($sformatf("rand%0d rx_data", r), int'(rx_data), int'(model_data));
            last_bad_stop = !stop;
        end

        idle(50);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
